compressor42_row_pipe: RTL and testbench
========================================

// Module: compressor42_row_pipe
// PURPOSE
//  Parametrised, pipelined row of 4:2 compressors with a final carry-propagate adder (CPA).
//  Reduces four WIDTH-bit unsigned operands plus a carry-in to a single resolved sum.
//  Used as a partial-product reduction stage in the Wallace-tree multiplier datapath.
//  A valid/ready handshake on both sides gives full-throughput, stall-safe streaming.
// PARAMETERS
//  WIDTH     8  operand width in bits; legal range 2..32
//  PIPE_CPA  1  1: CPA result is registered (latency 2). 0: CPA is combinational from stage-1 registers (latency 1)
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operands and cin are valid this cycle
//  in_ready   out  1        block accepts operands this cycle
//  a0..a3     in   WIDTH    four operands, unsigned (four separate ports)
//  cin        in   1        carry-in, weight 2^0
//  out_valid  out  1        res is valid
//  out_ready  in   1        downstream accepts res
//  res        out  WIDTH+2  a0+a1+a2+a3+cin
//  sum_vec    out  WIDTH    stage-1 redundant sum (debug), weight 2^i
//  car_vec    out  WIDTH    stage-1 redundant carry (debug), weight 2^(i+1)
// BEHAVIOUR
//  Cell i (i=0..WIDTH-1) takes a0[i]..a3[i], ci[i]. ci[0]=cin; ci[i+1]=co[i].
//   x1 = a0^a1;  x2 = a2^a3
//   co = x1 ? a2 : a0
//   s  = x1^x2^ci
//   c  = (x1^x2) ? ci : a3
//  co[i] never depends on ci[i]: there is no ripple through co.
//  Identity: sum_vec + (car_vec<<1) + (co[WIDTH-1]<<WIDTH) == a0+a1+a2+a3+cin.
//  Stage 1 (S1): registers s1_sum, s1_car, s1_cout, s1_v.
//   S1 loads on in_valid && in_ready.
//  CPA: res_n = s1_sum + (s1_car<<1) + (s1_cout<<WIDTH), computed at WIDTH+2 bits. It never overflows.
//  PIPE_CPA=1:
//   Stage 2 (S2) registers res and out_valid from S1 when S2 is empty or out_ready=1.
//   s2_adv = !out_valid || out_ready;  in_ready = !rst && (!s1_v || s2_adv)
//   S1 drains into S2 on s1_v && s2_adv.
//   S1 clears s1_v on drain unless it reloads in the same cycle.
//  PIPE_CPA=0:
//   res = res_n;  out_valid = s1_v;  in_ready = !rst && (!s1_v || out_ready)
//  Latency: PIPE_CPA=1 -> 2 cycles; PIPE_CPA=0 -> 1 cycle (in accept edge to out_valid).
//  Throughput: one operation per cycle while out_ready=1.
//  Stall: while out_valid && !out_ready, res and out_valid hold stable.
//   S1 holds its contents if full; in_ready drops only when both stages are full.
//  Simultaneous accept + drain in the same cycle is legal. No bubble is inserted and no data is lost.
//  Reset:
//   All registers clear: s1_*=0, res=0, out_valid=0, sum_vec=0, car_vec=0.
//   in_ready=0 while rst=1 and 1 in the first cycle after reset.
//   Reset mid-stream discards all in-flight data; no partial result is ever emitted.
//  Inputs are ignored when in_valid=0 or in_ready=0. Operand X on an ignored cycle must not propagate.
//  sum_vec and car_vec mirror s1_sum and s1_car.
// TESTING
//  T1 WIDTH=8: a0..a3=8'hFF, cin=1, out_ready=1 -> res=10'h3FD, out_valid 2 cycles after accept.
//  T2 Identity check: a0=3, a1=5, a2=9, a3=17, cin=0 -> res=34.
//   Also check sum_vec+(car_vec<<1)+(cout<<8)=34 in stage 1.
//  T3 Back-to-back: 4 ops on consecutive cycles, out_ready=1 -> 4 results on consecutive cycles, in order.
//   in_ready stays 1 throughout.
//  T4 Backpressure: out_ready=0 for 5 cycles while sending 3 ops.
//   -> in_ready drops after 2 accepts; res holds op1.
//   -> On release, op1, op2, op3 emerge in order with no loss or duplication.
//  T5 Reset mid-stream: assert rst for 1 cycle with S1 and S2 full.
//   -> out_valid=0, res=0 next cycle; no stale result appears afterwards.
//  T6 PIPE_CPA=0, WIDTH=16: a0..a3=16'hFFFF, cin=1 -> res=18'h3FFFD, 1 cycle after accept.
//   Plus a random 10k-op scoreboard against a0+a1+a2+a3+cin with random out_ready.

Source files
------------

// File: rtl/compressor42_row_pipe.sv
// rtl/compressor42_row_pipe.sv - pipelined row of 4:2 compressors with final CPA
// Reduces four unsigned operands plus carry-in to one sum behind a valid/ready pipeline.
module compressor42_row_pipe #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          PIPE_CPA = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   a2,
  input  logic [WIDTH-1:0]   a3,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:0]   res,
  output logic [WIDTH-1:0]   sum_vec,
  output logic [WIDTH-1:0]   car_vec
);

  logic [WIDTH-1:0] x1_w, x2_w, s_w, c_w, co_w, ci_w;

  // co of each cell depends only on its operand bits, so the ci chain never ripples.
  assign ci_w = {co_w[WIDTH-2:0], cin};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign x1_w[i] = a0[i] ^ a1[i];
    assign x2_w[i] = a2[i] ^ a3[i];
    assign co_w[i] = x1_w[i] ? a2[i] : a0[i];
    assign s_w[i]  = x1_w[i] ^ x2_w[i] ^ ci_w[i];
    assign c_w[i]  = (x1_w[i] ^ x2_w[i]) ? ci_w[i] : a3[i];
  end

  logic [WIDTH-1:0] s1_sum_q, s1_sum_d;
  logic [WIDTH-1:0] s1_car_q, s1_car_d;
  logic             s1_cout_q, s1_cout_d;
  logic             s1_v_q, s1_v_d;
  logic             drain_ok_w;
  logic             accept_w;
  logic [WIDTH+1:0] res_n_w;

  assign in_ready = !rst && (!s1_v_q || drain_ok_w);
  assign accept_w = in_valid && in_ready;

  always_comb begin
    s1_sum_d  = s1_sum_q;
    s1_car_d  = s1_car_q;
    s1_cout_d = s1_cout_q;
    s1_v_d    = s1_v_q;
    if (accept_w) begin
      s1_sum_d  = s_w;
      s1_car_d  = c_w;
      s1_cout_d = co_w[WIDTH-1];
      s1_v_d    = 1'b1;
    end else if (s1_v_q && drain_ok_w) begin
      s1_v_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sum_q  <= '0;
      s1_car_q  <= '0;
      s1_cout_q <= 1'b0;
      s1_v_q    <= 1'b0;
    end else begin
      s1_sum_q  <= s1_sum_d;
      s1_car_q  <= s1_car_d;
      s1_cout_q <= s1_cout_d;
      s1_v_q    <= s1_v_d;
    end
  end

  assign sum_vec = s1_sum_q;
  assign car_vec = s1_car_q;

  // Final resolution; WIDTH+2 bits always holds four full operands plus carry-in.
  assign res_n_w = {2'b00, s1_sum_q}
                 + {1'b0, s1_car_q, 1'b0}
                 + {1'b0, s1_cout_q, {WIDTH{1'b0}}};

  if (PIPE_CPA) begin : g_pipe
    logic [WIDTH+1:0] res_q, res_d;
    logic             ov_q, ov_d;

    assign drain_ok_w = !ov_q || out_ready;

    always_comb begin
      res_d = res_q;
      ov_d  = ov_q;
      if (drain_ok_w) begin
        ov_d = s1_v_q;
        if (s1_v_q) begin
          res_d = res_n_w;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        res_q <= '0;
        ov_q  <= 1'b0;
      end else begin
        res_q <= res_d;
        ov_q  <= ov_d;
      end
    end

    assign res       = res_q;
    assign out_valid = ov_q;
  end else begin : g_comb
    assign drain_ok_w = out_ready;
    assign res        = res_n_w;
    assign out_valid  = s1_v_q;
  end

endmodule

// File: tb/tb_compressor42_row_pipe.sv
// tb/tb_compressor42_row_pipe.sv - randomized scoreboard bench for compressor42_row_pipe
// Instance A: WIDTH=8 registered CPA; instance B: WIDTH=16 combinational CPA.
module tb_compressor42_row_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_cin, a_ov, a_or;
  logic [7:0]  a_a0, a_a1, a_a2, a_a3, a_sv, a_cv;
  logic [9:0]  a_res;
  logic        b_iv, b_ir, b_cin, b_ov, b_or;
  logic [15:0] b_a0, b_a1, b_a2, b_a3, b_sv, b_cv;
  logic [17:0] b_res;

  compressor42_row_pipe #(.WIDTH(8), .PIPE_CPA(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir),
    .a0(a_a0), .a1(a_a1), .a2(a_a2), .a3(a_a3), .cin(a_cin),
    .out_valid(a_ov), .out_ready(a_or), .res(a_res), .sum_vec(a_sv), .car_vec(a_cv)
  );

  compressor42_row_pipe #(.WIDTH(16), .PIPE_CPA(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir),
    .a0(b_a0), .a1(b_a1), .a2(b_a2), .a3(b_a3), .cin(b_cin),
    .out_valid(b_ov), .out_ready(b_or), .res(b_res), .sum_vec(b_sv), .car_vec(b_cv)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_sum(input bit sel, input logic [15:0] x0, x1, x2, x3,
                                          input logic c);
    logic [63:0] m;
    m = sel ? 64'hFFFF : 64'hFF;
    return (64'(x0) & m) + (64'(x1) & m) + (64'(x2) & m) + (64'(x3) & m) + 64'(c);
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [15:0] x0, x1, x2, x3,
                       input logic c);
    if (!sel) begin
      a_iv = v; a_a0 = x0[7:0]; a_a1 = x1[7:0]; a_a2 = x2[7:0]; a_a3 = x3[7:0]; a_cin = c;
    end else begin
      b_iv = v; b_a0 = x0; b_a1 = x1; b_a2 = x2; b_a3 = x3; b_cin = c;
    end
  endtask

  // Returns edges from the accept edge (inclusive) until out_valid is seen.
  task automatic measure(input bit sel, input logic [15:0] x, input logic c,
                         output int lat, output logic [63:0] r);
    @(posedge clk); #1;
    drive(sel, 1'b1, x, x, x, x, c);
    @(negedge clk);
    chk("lat_ready", 64'(sel ? b_ir : a_ir), 64'd1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    lat = 1;
    r = '0;
    while (lat < 10) begin
      @(negedge clk);
      if (sel ? b_ov : a_ov) begin
        r = sel ? 64'(b_res) : 64'(a_res);
        break;
      end
      @(posedge clk);
      lat++;
    end
    @(posedge clk);
  endtask

  task automatic run_random(input bit sel, input int n);
    logic [63:0] q[$];
    logic [63:0] hold_res;
    logic [15:0] r0, r1, r2, r3;
    logic        rc, iv, orr, ov, ir;
    logic [63:0] rs;
    bit          stalled = 0;
    int          sent = 0, got = 0, cyc = 0;
    while (got < n && cyc < 10 * n) begin
      @(posedge clk); #1;
      r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
      rc = 1'($urandom);
      iv = (sent < n) && ($urandom_range(0, 3) != 0);
      orr = ($urandom_range(0, 3) != 0);
      drive(sel, iv, r0, r1, r2, r3, rc);
      if (sel) b_or = orr; else a_or = orr;
      @(negedge clk);
      ov = sel ? b_ov : a_ov;
      ir = sel ? b_ir : a_ir;
      rs = sel ? 64'(b_res) : 64'(a_res);
      if (stalled) begin
        chk("stall_valid", 64'(ov), 64'd1);
        chk("stall_res", rs, hold_res);
      end
      if (ov && orr) begin
        if (q.size() == 0) chk("spurious_out", 64'd1, 64'd0);
        else chk("rand_res", rs, q.pop_front());
        got++;
      end
      if (iv && ir) begin
        q.push_back(ref_sum(sel, r0, r1, r2, r3, rc));
        sent++;
      end
      stalled  = ov && !orr;
      hold_res = rs;
      cyc++;
    end
    chk("rand_count", 64'(got), 64'(n));
    @(posedge clk); #1;
    drive(sel, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin : main
    int          lat;
    logic [63:0] r;
    logic [7:0]  ops[4];
    logic [63:0] outs[$];
    int          idx[$];
    int          sent;

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    a_or = 1'b1; b_or = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_a", 64'(a_ir), 64'd0);
    chk("rst_in_ready_b", 64'(b_ir), 64'd0);
    chk("rst_out_valid", 64'(a_ov), 64'd0);
    chk("rst_res", 64'(a_res), 64'd0);
    chk("rst_sum_car", {32'(a_sv), 32'(a_cv)}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(a_ir), 64'd1);

    // T1: all-ones WIDTH=8, two-cycle latency
    measure(1'b0, 16'h00FF, 1'b1, lat, r);
    chk("t1_latency", 64'(lat), 64'd2);
    chk("t1_res", r, 64'h3FD);

    // T2: redundant form in stage 1 resolves to the same sum
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 16'd3, 16'd5, 16'd9, 16'd17, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    chk("t2_identity", 64'(a_sv) + (64'(a_cv) << 1) + (64'(dut_a.s1_cout_q) << 8), 64'd34);
    @(negedge clk);
    chk("t2_valid", 64'(a_ov), 64'd1);
    chk("t2_res", 64'(a_res), 64'd34);
    @(posedge clk);

    // T3: back-to-back
    for (int k = 0; k < 4; k++) ops[k] = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k < 4) drive(1'b0, 1'b1, 16'(ops[k]), 16'(ops[k] ^ 8'h5A), 16'(k), 16'hFF, k[0]);
      else drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      if (k < 4) chk("t3_in_ready", 64'(a_ir), 64'd1);
      if (a_ov) begin outs.push_back(64'(a_res)); idx.push_back(k); end
    end
    chk("t3_count", 64'(outs.size()), 64'd4);
    for (int j = 0; j < 4 && j < outs.size(); j++) begin
      chk("t3_res", outs[j], ref_sum(1'b0, 16'(ops[j]), 16'(ops[j] ^ 8'h5A), 16'(j), 16'hFF, j[0]));
      chk("t3_cycle", 64'(idx[j]), 64'(2 + j));
    end

    // T4: backpressure with three ops
    outs.delete();
    for (int k = 0; k < 3; k++) ops[k] = 8'($urandom);
    a_or = 1'b0;
    sent = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 16'(ops[sent]), 16'd1, 16'd2, 16'd3, 1'b0);
      @(negedge clk);
      if (a_ir) sent++;
    end
    chk("t4_accepts", 64'(sent), 64'd2);
    chk("t4_in_ready", 64'(a_ir), 64'd0);
    chk("t4_valid", 64'(a_ov), 64'd1);
    chk("t4_hold", 64'(a_res), ref_sum(1'b0, 16'(ops[0]), 16'd1, 16'd2, 16'd3, 1'b0));
    for (int k = 0; k < 20 && outs.size() < 3; k++) begin
      @(posedge clk); #1;
      a_or = 1'b1;
      if (sent < 3) drive(1'b0, 1'b1, 16'(ops[sent]), 16'd1, 16'd2, 16'd3, 1'b0);
      else drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      if (a_ov) outs.push_back(64'(a_res));
      if (a_iv && a_ir) sent++;
    end
    chk("t4_count", 64'(outs.size()), 64'd3);
    for (int j = 0; j < 3 && j < outs.size(); j++)
      chk("t4_order", outs[j], ref_sum(1'b0, 16'(ops[j]), 16'd1, 16'd2, 16'd3, 1'b0));
    @(posedge clk); #1 drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    chk("t4_no_dup", 64'(a_ov), 64'd0);

    // T5: reset with both stages full
    a_or = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1 drive(1'b0, 1'b1, 16'hAA, 16'h55, 16'h0F, 16'hF0, 1'b1);
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    chk("t5_full", {63'd0, a_ov} + {63'd0, dut_a.s1_v_q}, 64'd2);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_ready", 64'(a_ir), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", 64'(a_ov), 64'd0);
    chk("t5_res", 64'(a_res), 64'd0);
    chk("t5_sum_vec", 64'(a_sv), 64'd0);
    a_or = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_no_stale", 64'(a_ov), 64'd0);
    end

    // T6: combinational CPA, WIDTH=16
    measure(1'b1, 16'hFFFF, 1'b1, lat, r);
    chk("t6_latency", 64'(lat), 64'd1);
    chk("t6_res", r, 64'h3FFFD);

    run_random(1'b0, 10000);
    run_random(1'b1, 10000);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
